// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shifter: a shift by cnt is composed from power-of-two
// steps (one per set bit of cnt), so latency is popcount(cnt) SHIFT cycles.
module shift_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in_data,
  input  logic [1:0]  op,
  input  logic [3:0]  cnt,
  output logic        busy,
  output logic        done,
  output logic [15:0] out_data
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned OW = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   work_q, work_d;
  logic [OW-1:0]   op_q, op_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [CW-1:0]   step_c;
  logic            busy_q, done_q;

  // Single shift of d by k using the given op encoding.
  function automatic logic [DW-1:0] shift_k(input logic [DW-1:0] d,
                                            input logic [OW-1:0] o,
                                            input logic [CW-1:0] k);
    logic [2*DW-1:0] dbl;
    logic [DW-1:0]   r;
    dbl = {d, d} << k;
    r   = d;
    case (o)
      2'b00: r = dbl[2*DW-1:DW];
      2'b01: r = d << k;
      2'b10: r = DW'($unsigned($signed(d) >>> k));
      2'b11: r = d >> k;
      default: r = d;
    endcase
    return r;
  endfunction

  // Lowest set bit of rem is the step size for this cycle.
  assign step_c = rem_q & (~rem_q + CW'(1));

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          work_d  = in_data;
          op_d    = op;
          rem_d   = cnt;
          state_d = (cnt != '0) ? ST_SHIFT : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = shift_k(work_q, op_q, step_c);
        rem_d  = rem_q & ~step_c;
        if (rem_d == '0) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d == ST_SHIFT);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed corner cases plus a
// randomized op x cnt sweep against a bit-at-a-time reference shifter.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in_data;
  logic [1:0]  op;
  logic [3:0]  cnt;
  logic        busy;
  logic        done;
  logic [15:0] out_data;

  int checks;
  int failures;

  shift_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_data  (in_data),
    .op       (op),
    .cnt      (cnt),
    .busy     (busy),
    .done     (done),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: apply cnt single-bit shifts.
  function automatic logic [15:0] ref_shift(input logic [15:0] d,
                                            input logic [1:0] o,
                                            input int c);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < c; i++) begin
      case (o)
        2'b00: r = {r[14:0], r[15]};
        2'b01: r = {r[14:0], 1'b0};
        2'b10: r = {r[15], r[15:1]};
        default: r = {1'b0, r[15:1]};
      endcase
    end
    return r;
  endfunction

  task automatic drive_start(input logic [15:0] d, input logic [1:0] o,
                             input logic [3:0] c);
    start   = 1'b1;
    in_data = d;
    op      = o;
    cnt     = c;
  endtask

  // Called at a negedge right after drive_start; measures the transaction.
  // With noise set, start is pulsed with random operands while in SHIFT.
  task automatic wait_result(input bit noise, output logic [15:0] res,
                             output int lat, output int bcnt,
                             output bit overlap);
    res = 'x; bcnt = 0; overlap = 1'b0;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      if (busy && done) overlap = 1'b1;
      if (busy) bcnt++;
      in_data = 16'($urandom);
      op      = 2'($urandom);
      cnt     = 4'($urandom);
      if (done) begin
        res   = out_data;
        start = 1'b0;
        break;
      end
      start = noise ? 1'b1 : 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_start(16'hBEEF, 2'b01, 4'd3);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out got=%h exp=0000", out_data); end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] d [4] = '{16'h8001, 16'h00FF, 16'h8000, 16'h8000};
    logic [1:0]  o [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0]  c [4] = '{4'd4, 4'd15, 4'd3, 4'd15};
    logic [15:0] e [4] = '{16'h0018, 16'h8000, 16'hF000, 16'h0001};
    int          el[4] = '{2, 5, 3, 5};
    logic [15:0] res; int lat, bc; bit ov;
    for (int i = 0; i < 4; i++) begin
      drive_start(d[i], o[i], c[i]);
      wait_result(1'b0, res, lat, bc, ov);
      checks++; if (res !== e[i]) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, e[i]); end
      checks++; if (lat != el[i]) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, el[i]); end
      checks++; if (bc != el[i] - 1) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, el[i] - 1); end
      @(negedge clk);
    end
  endtask

  task automatic test_cnt_zero();
    logic [15:0] res; int lat, bc; bit ov;
    drive_start(16'h1234, 2'($urandom), 4'd0);
    wait_result(1'b0, res, lat, bc, ov);
    checks++; if (res !== 16'h1234) begin failures++; $display("FAIL zero_result got=%h exp=1234", res); end
    checks++; if (lat != 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    checks++; if (bc != 0) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=0", bc); end
    @(negedge clk);
  endtask

  task automatic test_start_in_shift();
    logic [15:0] res; int lat, bc; bit ov;
    logic [15:0] d;
    d = 16'($urandom);
    drive_start(d, 2'b11, 4'd15);
    wait_result(1'b1, res, lat, bc, ov);
    checks++; if (res !== ref_shift(d, 2'b11, 15)) begin failures++; $display("FAIL ignore_result got=%h exp=%h", res, ref_shift(d, 2'b11, 15)); end
    checks++; if (lat != 5) begin failures++; $display("FAIL ignore_latency got=%0d exp=5", lat); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL post_done_idle got=%b%b exp=00", busy, done); end
    checks++; if (out_data !== res) begin failures++; $display("FAIL hold_result got=%h exp=%h", out_data, res); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra, rb; int la, lb, ba, bb; bit oa, ob;
    logic [15:0] da, db;
    da = 16'($urandom); db = 16'($urandom);
    drive_start(da, 2'b00, 4'd5);
    wait_result(1'b0, ra, la, ba, oa);
    drive_start(db, 2'b10, 4'd6);
    wait_result(1'b0, rb, lb, bb, ob);
    checks++; if (ra !== ref_shift(da, 2'b00, 5)) begin failures++; $display("FAIL b2b_a_result got=%h exp=%h", ra, ref_shift(da, 2'b00, 5)); end
    checks++; if (rb !== ref_shift(db, 2'b10, 6)) begin failures++; $display("FAIL b2b_b_result got=%h exp=%h", rb, ref_shift(db, 2'b10, 6)); end
    checks++; if (lb != 3) begin failures++; $display("FAIL b2b_b_latency got=%0d exp=3", lb); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] res; int lat, bc, dcount; bit ov;
    drive_start(16'hA5C3, 2'b00, 4'd15);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_flags got=%b%b exp=00", busy, done); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL abort_out got=%h exp=0000", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcount++;
    end
    checks++; if (dcount != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dcount); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_start(16'h5A5A, 2'b01, 4'd0);
    wait_result(1'b0, res, lat, bc, ov);
    checks++; if (res !== 16'h5A5A || lat != 1) begin failures++; $display("FAIL first_edge_start got=%h/%0d exp=5a5a/1", res, lat); end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [15:0] res, d, exp_r; int lat, bc, pc; bit ov;
    int ovc;
    ovc = 0;
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 16; c++) begin
        d = 16'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        drive_start(d, 2'(o), 4'(c));
        wait_result(1'b0, res, lat, bc, ov);
        if (ov) ovc++;
        exp_r = ref_shift(d, 2'(o), c);
        pc = $countones(4'(c));
        checks++; if (res !== exp_r) begin failures++; $display("FAIL sweep_result op=%0d cnt=%0d got=%h exp=%h", o, c, res, exp_r); end
        checks++; if (lat != pc + 1) begin failures++; $display("FAIL sweep_latency op=%0d cnt=%0d got=%0d exp=%0d", o, c, lat, pc + 1); end
        checks++; if (bc != pc) begin failures++; $display("FAIL sweep_busy op=%0d cnt=%0d got=%0d exp=%0d", o, c, bc, pc); end
      end
    end
    checks++; if (ovc != 0) begin failures++; $display("FAIL busy_done_overlap got=%0d exp=0", ovc); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; in_data = '0; op = '0; cnt = '0;
    test_reset();
    test_directed();
    test_cnt_zero();
    test_start_in_shift();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 16 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be as follows, in this order:
- `clk  input  1` -- rising-edge clock.
- `rst_n  input  1` -- asynchronous, active-low reset.
- `start  input  1` -- request a shift operation.
- `in_data  input  16` -- operand.
- `op  input  2` -- shift operation: 00 rotate-left, 01 shift-left-logical, 10 shift-right-arithmetic, 11 shift-right-logical.
- `cnt  input  4` -- shift amount, 0..15.
- `busy  output  1` -- an operation is in progress.
- `done  output  1` -- one-cycle pulse; result valid.
- `out_data  output  16` -- result register.

Function
REQ-004 The state machine SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-005 A start SHALL be accepted only on a rising edge where start=1 and the state is IDLE or DONE; start in SHIFT SHALL be ignored, with no queuing.
REQ-006 On accept, the block SHALL:
- latch in_data into the work register, op into the op register and cnt into the remaining-count register (rem);
- go to SHIFT if cnt!=0, otherwise to DONE.
REQ-007 On each SHIFT edge, the block SHALL:
- shift the work register by k, where k is the value of the lowest set bit of rem (1, 2, 4 or 8), using the latched op;
- clear that bit of rem.
REQ-008 SHIFT SHALL go to DONE on the edge that clears the last set bit of rem; the shift latency in SHIFT is therefore popcount(cnt) cycles.
REQ-009 DONE SHALL last exactly one cycle and then go to IDLE, unless a new start is accepted on that edge, per REQ-005/006.
REQ-010 Shift semantics for a shift by k SHALL be:
- rotate-left: bits wrap from bit 15 to bit 0;
- shift-left-logical: zero fill from the LSB;
- shift-right-arithmetic: fill with the current bit 15;
- shift-right-logical: zero fill from the MSB.
REQ-011 The composed result SHALL equal a single shift by cnt for every op and cnt 0..15.
REQ-012 cnt=0 SHALL produce out_data=in_data with done asserted in the cycle following the accept edge.
REQ-013 Output timing SHALL be:
- busy=1 exactly while in SHIFT;
- done=1 exactly while in DONE;
- busy and done never both high.
REQ-014 out_data SHALL drive the work register directly.
- It holds intermediate values during SHIFT.
- It is valid when done=1 and stays stable until the next accepted start.
REQ-015 in_data, op and cnt SHALL be sampled only on the accept edge; changes at any other time SHALL have no effect.
REQ-016 Total latency from the accept edge to done=1 SHALL be popcount(cnt)+1 cycles: 1 for cnt=0, 5 for cnt=15.

Reset
REQ-017 While rst_n=0, regardless of clk, the block SHALL hold:
- state=IDLE;
- work register, op register and rem all zero;
- busy=0, done=0, out_data=0x0000.
REQ-018 Reset asserted mid-operation SHALL abort immediately: no done pulse, no partial result retained.
REQ-019 Release of rst_n SHALL take effect at the next clk edge, and start SHALL be honoured on the first edge with rst_n=1.

Verification
REQ-020 The bench SHALL cover: op=00, in_data=0x8001, cnt=4 -> out_data=0x0018; busy high 1 cycle; done 2 cycles after accept.
REQ-021 The bench SHALL cover: op=01, in_data=0x00FF, cnt=15 -> out_data=0x8000; busy high 4 cycles; done 5 cycles after accept.
REQ-022 The bench SHALL cover: op=10, in_data=0x8000, cnt=3 -> out_data=0xF000; op=11, same in_data, cnt=15 -> out_data=0x0001.
REQ-023 The bench SHALL cover: cnt=0, in_data=0x1234, any op -> out_data=0x1234; done the cycle after accept; busy never high.
REQ-024 The bench SHALL cover a pulse of start during SHIFT with different operands -> ignored; the original result still completes with unchanged latency.
REQ-025 The bench SHALL cover a back-to-back start in the DONE cycle -> accepted, with no idle gap.
REQ-026 The bench SHALL cover rst_n=0 during SHIFT -> busy=0, done=0 and out_data=0x0000 immediately, with no done pulse after release.
REQ-027 The bench SHALL cover a randomized sweep of all op × cnt 0..15 against a reference shift model, checking result and latency each time.
